rv32_alu_share_ctrl: RTL

// - Shares one multicycle ALU FSM (rv32_alu_fsm) between two requesters:
//   req0 = execute stage, req1 = address/branch-compare unit.
// - Arbitrates round-robin, launches one operation at a time on the ALU and

---
 rtl/rv32_alu_share_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rv32_alu_share_ctrl.sv
// Round-robin share controller placing one multicycle rv32_alu_fsm behind two requesters.
// Optional wait-timeout error path is compiled in with `define ALU_TIMEOUT_EN.
module rv32_alu_share_ctrl #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_req_valid,
  input  logic [2*XLEN-1:0] i_req_op_a,
  input  logic [2*XLEN-1:0] i_req_op_b,
  input  logic [3:0]        i_req_sel,
  output logic [1:0]        o_req_ready,
  output logic [1:0]        o_rsp_valid,
  output logic [XLEN-1:0]   o_rsp_result,
  output logic              o_rsp_carry,
  output logic              o_rsp_err,
  output logic              o_busy,
  output logic [XLEN-1:0]   o_alu_operand_one,
  output logic [XLEN-1:0]   o_alu_operand_two,
  output logic [1:0]        o_alu_sel,
  output logic              o_alu_stall_reset,
  input  logic              i_alu_data_valid,
  input  logic [XLEN-1:0]   i_alu_result,
  input  logic              i_alu_carry_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q;
  logic              rr_q;
  logic              gnt_q;
  logic [XLEN-1:0]   op_a_q;
  logic [XLEN-1:0]   op_b_q;
  logic [1:0]        sel_q;
  logic              stall_q;
  logic [1:0]        rsp_valid_q;
  logic [XLEN-1:0]   result_q;
  logic              carry_q;
  logic              err_q;

  logic              gnt_d;
  logic [XLEN-1:0]   op_a_d;
  logic [XLEN-1:0]   op_b_d;
  logic [1:0]        sel_d;
  logic              accept;
  logic              timeout;

  // Lone requester always wins; under contention the round-robin pointer decides.
  always_comb begin
    gnt_d  = (i_req_valid == 2'b11) ? rr_q : i_req_valid[1];
    op_a_d = gnt_d ? i_req_op_a[XLEN +: XLEN] : i_req_op_a[0 +: XLEN];
    op_b_d = gnt_d ? i_req_op_b[XLEN +: XLEN] : i_req_op_b[0 +: XLEN];
    sel_d  = gnt_d ? i_req_sel[3:2] : i_req_sel[1:0];
  end

  // Ready is gated by reset so every output reads 0 while i_rst is held.
  assign accept      = (state_q == S_IDLE) && (|i_req_valid) && !i_rst;
  assign o_req_ready = accept ? {gnt_d, ~gnt_d} : 2'b00;

`ifdef ALU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt_q;
  // Asserted in the TIMEOUT_CYCLES-th WAIT cycle.
  assign timeout = (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every register below updates with <= so all of them sample the
  // same pre-edge values; mixing in = would make results order-dependent.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      gnt_q       <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sel_q       <= 2'b00;
      stall_q     <= 1'b0;
      rsp_valid_q <= 2'b00;
      result_q    <= '0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      stall_q     <= 1'b0;
      rsp_valid_q <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            gnt_q   <= gnt_d;
            rr_q    <= ~gnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sel_q   <= sel_d;
            stall_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // ALU valid is stale here, so it is deliberately not looked at.
`ifdef ALU_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
`ifdef ALU_TIMEOUT_EN
          wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
          if (i_alu_data_valid) begin
            result_q    <= i_alu_result;
            carry_q     <= i_alu_carry_out;
            err_q       <= 1'b0;
            rsp_valid_q <= {gnt_q, ~gnt_q};
            state_q     <= S_RESP;
          end else if (timeout) begin
            result_q    <= '0;
            carry_q     <= 1'b0;
            err_q       <= 1'b1;
            rsp_valid_q <= {gnt_q, ~gnt_q};
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy            = (state_q != S_IDLE);
  assign o_rsp_valid       = rsp_valid_q;
  assign o_rsp_result      = result_q;
  assign o_rsp_carry       = carry_q;
  assign o_rsp_err         = err_q;
  assign o_alu_operand_one = op_a_q;
  assign o_alu_operand_two = op_b_q;
  assign o_alu_sel         = sel_q;
  assign o_alu_stall_reset = stall_q;

endmodule
